// File: rtl/miriscv_mem_arbiter_if.sv
// Signal bundle between miriscv_mem_arbiter, the core's fetch/LSU requesters and the shared
// memory bus. The master modport is the arbiter's view; slave is the surrounding system.
interface miriscv_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic              instr_req_i;
    logic [XLEN-1:0]   instr_addr_i;
    logic              instr_rvalid_o;
    logic [XLEN-1:0]   instr_rdata_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [XLEN/8-1:0] data_be_i;
    logic [XLEN-1:0]   data_addr_i;
    logic [XLEN-1:0]   data_wdata_i;
    logic              data_rvalid_o;
    logic [XLEN-1:0]   data_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN/8-1:0] mem_be_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [XLEN-1:0]   mem_rdata_i;

    modport master (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and LSU with one transaction
// outstanding; data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
module miriscv_mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    miriscv_mem_arbiter_if.master bus,
    output logic                  busy_o,
    output logic                  proto_err_o
);
    localparam int unsigned BeW         = XLEN / 8;
    localparam logic [3:0]  StarveLimit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
    typedef enum logic {OwnFetch, OwnData} owner_e;

    state_e          r_state;
    state_e          w_state_next;
    owner_e          r_owner;
    logic [3:0]      r_starve_cnt;
    logic            r_we;
    logic [BeW-1:0]  r_be;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;

    logic w_any_req;
    logic w_grant_data;
    logic w_arb;
    logic w_resp_done;

    assign w_any_req    = bus.instr_req_i | bus.data_req_i;
    assign w_grant_data = bus.data_req_i &
                          (~bus.instr_req_i | (r_starve_cnt != StarveLimit));
    assign w_arb        = (r_state == StIdle) & w_any_req;
    assign w_resp_done  = (r_state == StResp) & bus.mem_rvalid_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_next = StReq;
            StReq:   if (bus.mem_gnt_i) w_state_next = StResp;
            StResp:  if (bus.mem_rvalid_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Request attributes are captured once at arbitration so the bus stays stable while waiting.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_owner      <= OwnFetch;
            r_starve_cnt <= 4'd0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_arb) begin
            if (w_grant_data) begin
                r_owner <= OwnData;
                r_we    <= bus.data_we_i;
                r_be    <= bus.data_be_i;
                r_addr  <= bus.data_addr_i;
                r_wdata <= bus.data_wdata_i;
                if (!bus.instr_req_i) begin
                    r_starve_cnt <= 4'd0;
                end else if (r_starve_cnt != 4'hF) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_owner      <= OwnFetch;
                r_we         <= 1'b0;
                r_be         <= '1;
                r_addr       <= bus.instr_addr_i;
                r_wdata      <= '0;
                r_starve_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        bus.mem_req_o      = 1'b0;
        bus.mem_we_o       = 1'b0;
        bus.mem_be_o       = '0;
        bus.mem_addr_o     = '0;
        bus.mem_wdata_o    = '0;
        bus.instr_rvalid_o = 1'b0;
        bus.instr_rdata_o  = '0;
        bus.data_rvalid_o  = 1'b0;
        bus.data_rdata_o   = '0;

        if (r_state == StReq) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = r_we;
            bus.mem_be_o    = r_be;
            bus.mem_addr_o  = r_addr;
            bus.mem_wdata_o = r_wdata;
        end

        if (w_resp_done) begin
            if (r_owner == OwnData) begin
                bus.data_rvalid_o = 1'b1;
                bus.data_rdata_o  = bus.mem_rdata_i;
            end else begin
                bus.instr_rvalid_o = 1'b1;
                bus.instr_rdata_o  = bus.mem_rdata_i;
            end
        end

        busy_o      = (r_state != StIdle);
        proto_err_o = bus.mem_rvalid_i & (r_state != StResp);
    end
endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Self-checking bench for miriscv_mem_arbiter: cycle vector table, directed starvation and
// reset sequences, then randomized traffic against a transaction-level reference model.
module tb_miriscv_mem_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic arstn;
    logic busy;
    logic perr;

    int n_checks;
    int n_errors;

    miriscv_mem_arbiter_if #(.XLEN(32)) bus ();

    miriscv_mem_arbiter #(
        .XLEN        (32),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .bus        (bus),
        .busy_o     (busy),
        .proto_err_o(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_irv;
        logic [31:0] e_ird;
        logic        e_drv;
        logic [31:0] e_drd;
        logic        e_busy;
        logic        e_perr;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr,
                         input logic [31:0] dwd, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = iaddr;
        bus.data_req_i   = dreq;
        bus.data_we_i    = dwe;
        bus.data_be_i    = dbe;
        bus.data_addr_i  = daddr;
        bus.data_wdata_i = dwd;
        bus.mem_gnt_i    = gnt;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = rd;
    endtask

    // Compares every output against expectations; bus attributes only matter while requesting.
    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wd,
                            input logic e_irv, input logic [31:0] e_ird, input logic e_drv,
                            input logic [31:0] e_drd, input logic e_busy, input logic e_perr);
        chk({tag, " mem_req"}, bus.mem_req_o, e_req);
        chk({tag, " busy"}, busy, e_busy);
        chk({tag, " proto_err"}, perr, e_perr);
        chk({tag, " instr_rvalid"}, bus.instr_rvalid_o, e_irv);
        chk({tag, " instr_rdata"}, bus.instr_rdata_o, e_ird);
        chk({tag, " data_rvalid"}, bus.data_rvalid_o, e_drv);
        chk({tag, " data_rdata"}, bus.data_rdata_o, e_drd);
        if (e_req) begin
            chk({tag, " mem_addr"}, bus.mem_addr_o, e_addr);
            chk({tag, " mem_we"}, bus.mem_we_o, e_we);
            chk({tag, " mem_be"}, bus.mem_be_o, e_be);
            if (e_we) chk({tag, " mem_wdata"}, bus.mem_wdata_o, e_wd);
        end
    endtask

    // Reference model state for the random phase.
    int          m_phase;   // 0 idle, 1 request on bus, 2 awaiting response
    bit          m_own_d;
    int          m_cnt;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic        m_we;
    logic [3:0]  m_be;
    int          m_gw;
    int          m_rw;
    bit          ip;
    bit          dp;
    logic [31:0] ia;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] da;
    logic [31:0] dwd;

    initial begin
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_irv;
        logic        e_drv;
        bit          exp_f[10];

        n_checks = 0;
        n_errors = 0;
        arstn    = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        #12;
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset mem_addr", bus.mem_addr_o, 0);
        chk("reset mem_be", bus.mem_be_o, 0);
        chk("reset mem_we", bus.mem_we_o, 0);
        tick();
        arstn = 1'b1;

        vecs[0]  = '{1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0,
                     1, 32'h80, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 32'h13,
                     0, 0, 0, 0, 0, 1, 32'h13, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 1, 1, 4'h3, 32'h1004, 32'hBEEF, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 4; i < 7; i++) begin
            vecs[i] = '{0, 0, 1, 1, 4'h3, 32'h1004, 32'hBEEF, 0, 0, 0,
                        1, 32'h1004, 1, 4'h3, 32'hBEEF, 0, 0, 0, 0, 1, 0};
        end
        vecs[7]  = '{0, 0, 1, 1, 4'h3, 32'h1004, 32'hBEEF, 1, 0, 0,
                     1, 32'h1004, 1, 4'h3, 32'hBEEF, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 1, 1, 4'h3, 32'h1004, 32'hBEEF, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 1, 1, 4'h3, 32'h1004, 32'hBEEF, 0, 1, 32'h12345678,
                     0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{1, 32'h200, 1, 0, 4'hF, 32'h3000, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{1, 32'h200, 1, 0, 4'hF, 32'h3000, 0, 1, 0, 0,
                     1, 32'h3000, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0};
        vecs[14] = '{1, 32'h200, 1, 0, 4'hF, 32'h3000, 0, 0, 1, 32'hAAAA,
                     0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA, 1, 0};
        vecs[15] = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0,
                     1, 32'h200, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0};
        vecs[17] = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h5555,
                     0, 0, 0, 0, 0, 1, 32'h5555, 0, 0, 1, 0};
        vecs[18] = '{0, 0, 1, 0, 4'h1, 32'h40, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 1, 0, 4'h1, 32'h40, 0, 1, 1, 32'h99,
                     1, 32'h40, 0, 4'h1, 0, 0, 0, 0, 0, 1, 1};
        vecs[20] = '{0, 0, 1, 0, 4'h1, 32'h40, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[21] = '{0, 0, 1, 0, 4'h1, 32'h40, 0, 0, 1, 32'h7,
                     0, 0, 0, 0, 0, 0, 0, 1, 32'h7, 1, 0};

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].dbe,
                  vecs[i].daddr, vecs[i].dwd, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            #3;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_we,
                     vecs[i].e_be, vecs[i].e_wd, vecs[i].e_irv, vecs[i].e_ird,
                     vecs[i].e_drv, vecs[i].e_drd, vecs[i].e_busy, vecs[i].e_perr);
            tick();
        end

        // Both requesters held high: four data grants, then fetch, repeating.
        for (int k = 0; k < 10; k++) exp_f[k] = ((k % 5) == 4);
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'h100, 1, 0, 4'hF, 32'h2000, 0, 0, 0, 0);
            tick();
            bus.mem_gnt_i = 1'b1;
            #3;
            chk($sformatf("starve%0d mem_req", k), bus.mem_req_o, 1);
            chk($sformatf("starve%0d grant addr", k), bus.mem_addr_o,
                exp_f[k] ? 32'h100 : 32'h2000);
            tick();
            bus.mem_gnt_i    = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 32'(k);
            #3;
            chk($sformatf("starve%0d instr_rvalid", k), bus.instr_rvalid_o, exp_f[k]);
            chk($sformatf("starve%0d data_rvalid", k), bus.data_rvalid_o, !exp_f[k]);
            tick();
        end

        // Reset in the response phase abandons the transaction; the late response is stray.
        drive(0, 0, 1, 0, 4'hF, 32'h500, 0, 0, 0, 0);
        tick();
        bus.mem_gnt_i = 1'b1;
        tick();
        bus.mem_gnt_i = 1'b0;
        #1;
        chk("pre-reset busy", busy, 1);
        #1;
        arstn = 1'b0;
        #1;
        chk_outs("async reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.data_req_i = 1'b0;
        tick();
        arstn = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hCAFE;
        #3;
        chk_outs("late rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        bus.mem_rvalid_i = 1'b0;
        #3;
        chk_outs("after late rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Randomized traffic; starvation count restarts at zero after the reset above.
        m_phase = 0;
        m_cnt   = 0;
        m_own_d = 0;
        ip      = 0;
        dp      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ip && $urandom_range(3) == 0) begin
                ip = 1;
                ia = $urandom;
            end
            if (!dp && $urandom_range(2) == 0) begin
                dp  = 1;
                dwe = 1'($urandom_range(1));
                dbe = 4'($urandom_range(15));
                da  = $urandom;
                dwd = $urandom;
            end
            gnt = (m_phase == 1) ? (m_gw == 0) : ($urandom_range(7) == 0);
            rv  = (m_phase == 2) ? (m_rw == 0)
                                 : (m_phase == 0 && !ip && !dp && $urandom_range(15) == 0);
            rd  = $urandom;
            drive(ip, ia, dp, dwe, dbe, da, dwd, gnt, rv, rd);
            #3;
            e_irv = (m_phase == 2) && rv && !m_own_d;
            e_drv = (m_phase == 2) && rv && m_own_d;
            chk_outs($sformatf("rand%0d", c), m_phase == 1, m_addr, m_we, m_be, m_wd,
                     e_irv, e_irv ? rd : 32'h0, e_drv, e_drv ? rd : 32'h0,
                     m_phase != 0, rv && (m_phase != 2));
            case (m_phase)
                0: if (ip || dp) begin
                    m_own_d = dp && (!ip || m_cnt != STARVE_LIMIT);
                    if (m_own_d) begin
                        m_addr = da;
                        m_we   = dwe;
                        m_be   = dbe;
                        m_wd   = dwd;
                        m_cnt  = ip ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
                    end else begin
                        m_addr = ia;
                        m_we   = 0;
                        m_be   = 4'hF;
                        m_wd   = 0;
                        m_cnt  = 0;
                    end
                    m_phase = 1;
                    m_gw    = $urandom_range(3);
                end
                1: if (gnt) begin
                    m_phase = 2;
                    m_rw    = $urandom_range(2);
                end else begin
                    m_gw--;
                end
                default: if (rv) begin
                    m_phase = 0;
                    if (m_own_d) dp = 0;
                    else ip = 0;
                end else begin
                    m_rw--;
                end
            endcase
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/miriscv_mem_arbiter.md
Name: miriscv_mem_arbiter

Overview:
- Shares one external single-port memory bus between the core's instruction-fetch and data (LSU) interfaces.
- Used for single-memory SoC integration of miriscv_core.
- Arbitrates between the two requesters, keeps at most one transaction outstanding, and routes each response back to its owner.
- Data requests have priority over fetch; a starvation counter guarantees fetch progress.

Parameters:
- XLEN, 32, bus data/address width.
- STARVE_LIMIT, 4, number of consecutive data grants issued while a fetch is pending; the next grant then goes to fetch. Range 1..15.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request; held high with stable addr until instr_rvalid_o
- instr_addr_i  in  XLEN  fetch address
- instr_rvalid_o  out  1  fetch response valid, 1-cycle pulse
- instr_rdata_o  out  XLEN  fetch response data
- data_req_i  in  1  data request; held high with stable attributes until data_rvalid_o
- data_we_i  in  1  data write enable
- data_be_i  in  XLEN/8  data byte enables
- data_addr_i  in  XLEN  data address
- data_wdata_i  in  XLEN  data write data
- data_rvalid_o  out  1  data response valid, 1-cycle pulse (reads and writes)
- data_rdata_o  out  XLEN  data response data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_be_o  out  XLEN/8  bus byte enables
- mem_addr_o  out  XLEN  bus address
- mem_wdata_o  out  XLEN  bus write data
- mem_gnt_i  in  1  bus accepts request this cycle
- mem_rvalid_i  in  1  bus response valid (issued for writes too)
- mem_rdata_i  in  XLEN  bus response data
- busy_o  out  1  state != IDLE
- proto_err_o  out  1  1-cycle pulse on an unexpected mem_rvalid_i

Behaviour:
- Reset values: state=IDLE, owner=FETCH, starve_cnt=0. All outputs 0.
- Reset is asynchronous and may assert mid-transaction: the transaction is abandoned, no rvalid is produced, and any later bus response is treated as unexpected.
- FSM states:
  - IDLE: if data_req_i or instr_req_i is high, select an owner. Latch addr/we/be/wdata into registers; fetch forces we=0 and be=all ones. Go to REQ.
  - REQ: mem_req_o=1; mem_* outputs driven from the latched registers. On mem_gnt_i go to RESP; otherwise stay, with all mem_* outputs held stable.
  - RESP: mem_req_o=0. On mem_rvalid_i pulse the owner's rvalid, set the owner's rdata = mem_rdata_i (combinational), and go to IDLE.
- Owner selection:
  - Only one requester high: grant it.
  - Both high and starve_cnt == STARVE_LIMIT: grant fetch.
  - Both high otherwise: grant data.
- starve_cnt:
  - Increments (saturating) on each data grant made while instr_req_i is high.
  - Clears on any fetch grant.
  - Clears on a data grant made while instr_req_i is low.
- The non-owner's rvalid is 0.
- Each rdata output equals mem_rdata_i when that output's rvalid is high; 0 otherwise.
- Latency:
  - A request sampled in IDLE drives mem_req_o on the next cycle.
  - Best case (gnt in the first REQ cycle, rvalid in the first RESP cycle): requester rvalid 2 cycles after req is first sampled.
  - Back-to-back: the cycle after rvalid the FSM is in IDLE and may re-arbitrate. Throughput: 1 transaction per 3 cycles minimum.
- Requesters keep req high through the rvalid cycle. In the IDLE cycle after rvalid, the former owner's req being low (or already re-asserted for a new access) is legal.
- mem_gnt_i outside REQ is ignored.
- mem_rvalid_i outside RESP: ignored for routing, proto_err_o pulses, state unchanged.
- mem_rvalid_i in the same cycle the FSM enters RESP (i.e. coincident with gnt) is not accepted. The bus returns rvalid no earlier than the cycle after gnt.
- A requester dropping req mid-transaction does not abort it: the response is still consumed, and rvalid is still pulsed.

Test Plan:
- Fetch only: instr_req_i=1, addr=0x80; gnt and rvalid immediate, rdata=0x00000013 → mem_req_o high cycle 1 with addr 0x80, we=0, be=0xF; instr_rvalid_o pulses cycle 2 with 0x00000013.
- Data write: data_req_i=1, we=1, be=0x3, addr=0x1004, wdata=0xBEEF; gnt delayed 3 cycles → mem_* stable across all 3 wait cycles; data_rvalid_o one pulse after mem_rvalid_i; instr_rvalid_o stays 0.
- Simultaneous requests in IDLE with starve_cnt=0 → data granted first; fetch granted in the IDLE after data completes once data_req_i drops.
- Starvation: data_req_i and instr_req_i held high continuously, STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F.
- Stray mem_rvalid_i in IDLE → proto_err_o pulses 1 cycle; both rvalid outputs 0; state stays IDLE.
- arstn_i low during RESP → outputs 0 asynchronously; after release a late mem_rvalid_i produces proto_err_o and no requester rvalid.
